img_bw_frame_ctrl: RTL and testbench

- Frame sequencer for the grayscale-to-black/white pixel converter.
- On start, it scans a W x H source frame buffer in raster order over a synchronous-read port and drives each pixel into the combinational converter.
- It captures the converted pixel and emits it on a valid/ready output stream with frame/line markers.
- It sits between the frame-buffer RAM and the downstream writer/DMA, and latches the converter threshold per frame.

---
 rtl/img_bw_pkg.sv | 30 +++
 rtl/img_bw_skid_fifo.sv | 56 +++++
 rtl/img_bw_frame_ctrl.sv | 160 ++++++++++++++++
 tb/tb_img_bw_frame_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/img_bw_pkg.sv
// Shared types and default sizing for the grayscale-to-B/W frame sequencer.
// Provides: default frame geometry, derived width constants, the sequencer
// state enum, the 8-bit pixel type and the tagged output-beat payload.
package img_bw_pkg;

   localparam int unsigned W_DEF  = 256;
   localparam int unsigned H_DEF  = 256;
   localparam int unsigned ADDR_W = $clog2(W_DEF * H_DEF);
   localparam int unsigned XW     = $clog2(W_DEF);
   localparam int unsigned YW     = $clog2(H_DEF);
   localparam int unsigned PIX_W  = 8;

   typedef logic [PIX_W-1:0] pixel_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   // One output beat: converted pixel plus frame/line markers (11 bits).
   typedef struct packed {
      pixel_t data;
      logic   sof;
      logic   eol;
      logic   eof;
   } beat_t;

endpackage

// File: rtl/img_bw_skid_fifo.sv
// Two-entry output skid FIFO for tagged pixel beats.
// Ports: clk/rst (sync, active-high), clear (flush), push + wdata,
// pop, rdata (head beat, registered), valid (FIFO non-empty),
// occupancy (0..2).
// The head entry is a dedicated register so rdata never passes through a mux.
module img_bw_skid_fifo
   import img_bw_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clear,
   input  logic       push,
   input  beat_t      wdata,
   input  logic       pop,
   output beat_t      rdata,
   output logic       valid,
   output logic [1:0] occupancy
);

   beat_t      tail;
   logic [1:0] occ_nxt;

   // Occupancy update; overflow/underflow requests are ignored.
   always_comb begin
      occ_nxt = occupancy;
      case ({push, pop})
         2'b10:   if (occupancy != 2'd2) occ_nxt = occupancy + 2'd1;
         2'b01:   if (occupancy != 2'd0) occ_nxt = occupancy - 2'd1;
         default: occ_nxt = occupancy;
      endcase
   end

   // Head/tail storage: on pop the tail (or the incoming beat) moves to head.
   always_ff @(posedge clk) begin
      if (rst) begin
         occupancy <= 2'd0;
         valid     <= 1'b0;
         rdata     <= '0;
         tail      <= '0;
      end else if (clear) begin
         occupancy <= 2'd0;
         valid     <= 1'b0;
      end else begin
         occupancy <= occ_nxt;
         valid     <= (occ_nxt != 2'd0);
         if (pop) begin
            rdata <= (occupancy == 2'd2) ? tail : wdata;
            if (push && occupancy == 2'd2) tail <= wdata;
         end else if (push) begin
            if (occupancy == 2'd0)      rdata <= wdata;
            else if (occupancy == 2'd1) tail  <= wdata;
         end
      end
   end

endmodule

// File: rtl/img_bw_frame_ctrl.sv
// Frame sequencer for the grayscale-to-black/white converter.
// Scans a W x H frame buffer in raster order through a 1-cycle-latency read
// port, feeds each pixel to the combinational converter, and streams the
// converted pixels out on valid/ready with sof/eol/eof markers.
// Ports: clk, rst (sync, active-high); start/abort pulses; thr_in threshold
// (latched per frame onto conv_thr); busy/done status; mem_rd_en/mem_addr/
// mem_rdata RAM port; conv_pixel/conv_thr/conv_bw converter hookup;
// out_data/out_sof/out_eol/out_eof/out_valid/out_ready output stream.
module img_bw_frame_ctrl
   import img_bw_pkg::*;
#(
   parameter int unsigned W     = W_DEF,
   parameter int unsigned H     = H_DEF,
   parameter int unsigned DEPTH = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    abort,
   input  logic [7:0]              thr_in,
   output logic                    busy,
   output logic                    done,
   output logic                    mem_rd_en,
   output logic [$clog2(W*H)-1:0]  mem_addr,
   input  logic [7:0]              mem_rdata,
   output logic [7:0]              conv_pixel,
   output logic [7:0]              conv_thr,
   input  logic [7:0]              conv_bw,
   output logic [7:0]              out_data,
   output logic                    out_sof,
   output logic                    out_eol,
   output logic                    out_eof,
   output logic                    out_valid,
   input  logic                    out_ready
);

   localparam int unsigned FR_AW = $clog2(W * H);
   localparam int unsigned FR_XW = $clog2(W);
   localparam int unsigned FR_YW = $clog2(H);

   state_t           state, next_state;
   logic             inflight;
   logic [FR_XW-1:0] x;
   logic [FR_YW-1:0] y;
   logic             abort_act;
   logic             pop;
   logic             push;
   logic [1:0]       occ;
   beat_t            push_beat;
   beat_t            head;

   assign conv_pixel = mem_rdata;
   assign pop        = out_valid && out_ready;
   // RAM data returning in the abort cycle belongs to the cancelled frame.
   assign push       = inflight && !abort_act;

   assign out_data = head.data;
   assign out_sof  = head.sof;
   assign out_eol  = head.eol;
   assign out_eof  = head.eof;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // Next state and read issue. mem_rd_en must see this cycle's pop to keep
   // one pixel per cycle, so it is decoded combinationally from registered
   // state and out_ready.
   always_comb begin
      next_state = state;
      mem_rd_en  = 1'b0;
      abort_act  = 1'b0;
      unique case (state)
         IDLE: begin
            if (start && !abort) next_state = RUN;
         end
         RUN: begin
            if (abort) begin
               abort_act  = 1'b1;
               next_state = IDLE;
            end else begin
               // Issue only while FIFO entries + read in flight leave room.
               mem_rd_en = ({1'b0, occ} + 3'(inflight)) < (3'(DEPTH) + 3'(pop));
               if (mem_rd_en && mem_addr == FR_AW'(W * H - 1)) next_state = DRAIN;
            end
         end
         DRAIN: begin
            if (abort) begin
               abort_act  = 1'b1;
               next_state = IDLE;
            end else if (pop && head.eof) begin
               next_state = DONE;
            end
         end
         DONE: next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Tags come from the x/y counter that trails the read address by a cycle.
   always_comb begin
      push_beat      = '0;
      push_beat.data = conv_bw;
      push_beat.sof  = (x == '0) && (y == '0);
      push_beat.eol  = (x == FR_XW'(W - 1));
      push_beat.eof  = (x == FR_XW'(W - 1)) && (y == FR_YW'(H - 1));
   end

   // Status, address, threshold and raster counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy     <= 1'b0;
         done     <= 1'b0;
         mem_addr <= '0;
         conv_thr <= '0;
         inflight <= 1'b0;
         x        <= '0;
         y        <= '0;
      end else begin
         busy     <= (next_state == RUN) || (next_state == DRAIN);
         done     <= (next_state == DONE);
         inflight <= mem_rd_en;
         if (state == IDLE && next_state == RUN) begin
            conv_thr <= thr_in;
            mem_addr <= '0;
            x        <= '0;
            y        <= '0;
         end else if (abort_act) begin
            mem_addr <= '0;
            x        <= '0;
            y        <= '0;
         end else begin
            if (mem_rd_en) mem_addr <= mem_addr + FR_AW'(1);
            if (push) begin
               if (x == FR_XW'(W - 1)) begin
                  x <= '0;
                  y <= (y == FR_YW'(H - 1)) ? '0 : y + FR_YW'(1);
               end else begin
                  x <= x + FR_XW'(1);
               end
            end
         end
      end
   end

   img_bw_skid_fifo u_fifo (
      .clk       (clk),
      .rst       (rst),
      .clear     (abort_act),
      .push      (push),
      .wdata     (push_beat),
      .pop       (pop),
      .rdata     (head),
      .valid     (out_valid),
      .occupancy (occ)
   );

endmodule

// File: tb/tb_img_bw_frame_ctrl.sv
// Directed testbench for img_bw_frame_ctrl with W=4, H=4.
// RAM holds p[i]=16*i with one-cycle read latency; the converter outputs
// 0xFF when pixel >= threshold, else 0x00.
module tb_img_bw_frame_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic [7:0] thr_in = 8'h00;
   logic       busy, done, mem_rd_en;
   logic [3:0] mem_addr;
   logic [7:0] mem_rdata = 8'h00;
   logic [7:0] conv_pixel, conv_thr, conv_bw;
   logic [7:0] out_data;
   logic       out_sof, out_eol, out_eof, out_valid;
   logic       out_ready = 1'b1;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   logic [7:0] ram [16];
   logic [3:0] pat = 4'b1001;   // out_ready per cycle: 1,0,0,1 repeating

   // Monitor state (written only by the monitor process).
   int          outst = 0;
   int          viol = 0;
   int          done_cnt = 0;
   logic        stall_q = 1'b0;
   logic [10:0] stall_beat = '0;
   logic [10:0] bq [$];
   int          bc [$];

   img_bw_frame_ctrl #(.W(4), .H(4), .DEPTH(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .abort      (abort),
      .thr_in     (thr_in),
      .busy       (busy),
      .done       (done),
      .mem_rd_en  (mem_rd_en),
      .mem_addr   (mem_addr),
      .mem_rdata  (mem_rdata),
      .conv_pixel (conv_pixel),
      .conv_thr   (conv_thr),
      .conv_bw    (conv_bw),
      .out_data   (out_data),
      .out_sof    (out_sof),
      .out_eol    (out_eol),
      .out_eof    (out_eof),
      .out_valid  (out_valid),
      .out_ready  (out_ready)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (mem_rd_en) mem_rdata <= ram[mem_addr];
   end

   assign conv_bw = (conv_pixel >= conv_thr) ? 8'hFF : 8'h00;

   // Stream monitor: records accepted beats, checks the read-credit bound
   // and that a stalled beat is held unchanged.
   always @(negedge clk) begin
      if (rst) begin
         outst   <= 0;
         stall_q <= 1'b0;
      end else begin
         if (out_valid && out_ready) begin
            bq.push_back({out_data, out_sof, out_eol, out_eof});
            bc.push_back(cyc);
         end
         viol <= viol
               + ((stall_q && (!out_valid || {out_data, out_sof, out_eol, out_eof} != stall_beat)) ? 1 : 0)
               + ((mem_rd_en && (outst >= 2 + ((out_valid && out_ready) ? 1 : 0))) ? 1 : 0)
               + ((outst > 2) ? 1 : 0);
         done_cnt <= done_cnt + (done ? 1 : 0);
         if (abort && busy) begin
            outst   <= 0;
            stall_q <= 1'b0;
         end else begin
            outst      <= outst + (mem_rd_en ? 1 : 0) - ((out_valid && out_ready) ? 1 : 0);
            stall_q    <= out_valid && !out_ready;
            stall_beat <= {out_data, out_sof, out_eol, out_eof};
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drives a one-cycle start; returns the start cycle and monitor snapshots.
   task automatic begin_frame(input logic [7:0] thr, input bit bp,
                              output int c0, output int b0, output int d0);
      thr_in = thr;
      start  = 1'b1;
      c0     = cyc;
      b0     = bq.size();
      d0     = done_cnt;
      if (bp) out_ready = pat[0];
      step();
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input bit bp, input int c0);
      int idx;
      for (int n = 0; n < 200; n++) begin
         idx = (cyc - c0) % 4;
         if (bp) out_ready = pat[idx];
         if (done) break;
         step();
      end
      chk({tag, "_done_seen"}, done, 1);
   endtask

   task automatic check_beats(input string tag, input int b0, input int nz);
      logic [10:0] e;
      chk({tag, "_beat_count"}, bq.size() - b0, 16);
      for (int i = 0; i < 16; i++) begin
         e = {((i < nz) ? 8'h00 : 8'hFF), (i == 0), ((i % 4) == 3), (i == 15)};
         if (b0 + i < bq.size()) chk({tag, "_beat"}, bq[b0 + i], int'(e));
      end
   endtask

   initial begin
      int c0, b0, d0, v0, nb;
      for (int i = 0; i < 16; i++) ram[i] = 8'(16 * i);

      // Reset values.
      repeat (3) step();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_rd_en", mem_rd_en, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_tags", {out_sof, out_eol, out_eof}, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_thr", conv_thr, 0);
      rst = 1'b0;
      step();

      // Full frame, out_ready held high.
      begin_frame(8'h80, 1'b0, c0, b0, d0);
      chk("t1_busy_c1", busy, 1);
      chk("t1_rd_en_c1", mem_rd_en, 1);
      chk("t1_addr_c1", mem_addr, 0);
      chk("t1_thr", conv_thr, 8'h80);
      step();
      chk("t1_valid_c2", out_valid, 0);
      step();
      chk("t1_valid_c3", out_valid, 1);
      wait_done("t1", 1'b0, c0);
      chk("t1_done_cycle", cyc - c0, 19);
      chk("t1_busy_c19", busy, 0);
      check_beats("t1", b0, 8);
      for (int i = 0; i < 16; i++)
         if (b0 + i < bq.size()) chk("t1_beat_cycle", bc[b0 + i] - c0, 3 + i);
      step();
      chk("t1_done_pulse", done, 0);

      // Backpressure 1,0,0,1.
      v0 = viol;
      begin_frame(8'h80, 1'b1, c0, b0, d0);
      wait_done("bp", 1'b1, c0);
      out_ready = 1'b1;
      step();
      check_beats("bp", b0, 8);
      chk("bp_stream_rules", viol - v0, 0);
      chk("bp_done_count", done_cnt - d0, 1);

      // Threshold latched at start, later thr_in change ignored.
      begin_frame(8'h30, 1'b0, c0, b0, d0);
      repeat (4) step();
      thr_in = 8'hF0;
      step();
      chk("thr_mid", conv_thr, 8'h30);
      wait_done("thr", 1'b0, c0);
      chk("thr_end", conv_thr, 8'h30);
      step();
      check_beats("thr", b0, 3);

      // Abort at cycle 8.
      begin_frame(8'h80, 1'b0, c0, b0, d0);
      repeat (7) step();
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("ab_busy_c9", busy, 0);
      chk("ab_valid_c9", out_valid, 0);
      chk("ab_rd_en_c9", mem_rd_en, 0);
      nb = bq.size() - b0;
      chk("ab_beats", nb, 6);
      repeat (10) step();
      chk("ab_no_done", done_cnt - d0, 0);
      chk("ab_no_more_beats", bq.size() - b0, 6);
      // abort + start together while idle: stay idle.
      abort = 1'b1;
      start = 1'b1;
      step();
      abort = 1'b0;
      start = 1'b0;
      chk("ab_start_busy", busy, 0);
      step();
      chk("ab_start_rd_en", mem_rd_en, 0);
      begin_frame(8'h80, 1'b0, c0, b0, d0);
      wait_done("ab_re", 1'b0, c0);
      step();
      check_beats("ab_re", b0, 8);

      // Second start while busy is ignored.
      begin_frame(8'h80, 1'b0, c0, b0, d0);
      repeat (5) step();
      start = 1'b1;
      step();
      start = 1'b0;
      wait_done("sb", 1'b0, c0);
      repeat (6) step();
      check_beats("sb", b0, 8);
      chk("sb_done_count", done_cnt - d0, 1);
      chk("sb_idle", busy, 0);

      // Reset mid-frame at cycle 10.
      begin_frame(8'h80, 1'b0, c0, b0, d0);
      repeat (9) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mr_busy", busy, 0);
      chk("mr_done", done, 0);
      chk("mr_rd_en", mem_rd_en, 0);
      chk("mr_valid", out_valid, 0);
      chk("mr_tags", {out_sof, out_eol, out_eof}, 0);
      chk("mr_data", out_data, 0);
      chk("mr_addr", mem_addr, 0);
      chk("mr_thr", conv_thr, 0);
      step();
      begin_frame(8'h80, 1'b0, c0, b0, d0);
      wait_done("mr_re", 1'b0, c0);
      step();
      check_beats("mr_re", b0, 8);
      chk("mr_re_done_count", done_cnt - d0, 1);

      chk("stream_rules_all", viol, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
